// File: rtl/bin2dspl_formatter.sv
// Binary-to-display formatter for the 8-digit multiplexed 7-segment driver.
// Converts a 27-bit unsigned value to eight BCD digits using a serial
// double-dabble engine. The engine handles one bit per clock, so the latency
// is fixed at 28 clocks. The digit codes stay registered between conversions.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold the last result
//   SHIFT  | double-dabble, one input bit per clock (27 clocks)
//   FORMAT | blank/dp/overflow applied, digit codes registered, done pulsed
module bin2dspl_formatter #(
    parameter int BLANK_LEADING = 1,
    parameter int DP_POS        = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [26:0] value,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8
);

    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;

    localparam logic [26:0] MAX_DISPLAY = 27'd99_999_999;

    state_t      state, state_next;
    logic [26:0] shift_q;
    logic [31:0] bcd_q;
    logic [31:0] bcd_adj;
    logic [4:0]  count_q;
    logic        ovf_pending;
    logic [5:0]  digit_fmt [8];
    logic        seen_nonzero;
    logic        keep;
    logic [3:0]  nib;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode; the last shift happens on the edge where count is 1
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count_q == 5'd1) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    // Conversion datapath: load on accept, shift one bit per clock in SHIFT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bcd_q       <= '0;
            count_q     <= '0;
            ovf_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q     <= value;
                        bcd_q       <= '0;
                        count_q     <= 5'd27;
                        ovf_pending <= (value > MAX_DISPLAY);
                    end
                end
                SHIFT: begin
                    bcd_q   <= {bcd_adj[30:0], shift_q[26]};
                    shift_q <= {shift_q[25:0], 1'b0};
                    count_q <= count_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Digit formatting: leading-zero blanking from the top down, dp, overflow 'E'
    always_comb begin
        seen_nonzero = 1'b0;
        keep         = 1'b0;
        nib          = 4'h0;
        for (int k = 7; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
            if (nib != 4'h0) seen_nonzero = 1'b1;
            // Digits at or below the decimal point stay lit so "0.05" reads correctly
            keep = seen_nonzero || (k == 0) || (k < DP_POS) || (BLANK_LEADING == 0);
            digit_fmt[k] = keep ? {1'b1, nib, (DP_POS == k + 1)} : 6'h00;
        end
        if (ovf_pending) begin
            for (int k = 0; k < 7; k++) digit_fmt[k] = 6'h00;
            digit_fmt[7] = 6'h3C;
        end
    end

    // Registered outputs: digits and ovf change only on the FORMAT edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            ovf  <= 1'b0;
            d1   <= 6'h00;
            d2   <= 6'h00;
            d3   <= 6'h00;
            d4   <= 6'h00;
            d5   <= 6'h00;
            d6   <= 6'h00;
            d7   <= 6'h00;
            d8   <= 6'h00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) busy <= 1'b1;
                FORMAT: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    ovf  <= ovf_pending;
                    d1   <= digit_fmt[0];
                    d2   <= digit_fmt[1];
                    d3   <= digit_fmt[2];
                    d4   <= digit_fmt[3];
                    d5   <= digit_fmt[4];
                    d6   <= digit_fmt[5];
                    d7   <= digit_fmt[6];
                    d8   <= digit_fmt[7];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2dspl_formatter.sv
// Directed bench for bin2dspl_formatter: a default instance plus one with DP_POS=3.
module tb_bin2dspl_formatter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [26:0] value = '0;

    logic       busy, done, ovf;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       busy_p, done_p, ovf_p;
    logic [5:0] p1, p2, p3, p4, p5, p6, p7, p8;
    logic [47:0] disp, disp_dp;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    bin2dspl_formatter dut (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .ovf(ovf),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
    );

    bin2dspl_formatter #(.BLANK_LEADING(1), .DP_POS(3)) dut_dp (
        .clock(clock), .reset(reset), .start(start), .value(value),
        .busy(busy_p), .done(done_p), .ovf(ovf_p),
        .d1(p1), .d2(p2), .d3(p3), .d4(p4), .d5(p5), .d6(p6), .d7(p7), .d8(p8)
    );

    assign disp    = {d8, d7, d6, d5, d4, d3, d2, d1};
    assign disp_dp = {p8, p7, p6, p5, p4, p3, p2, p1};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a conversion from a sample point; returns just after the accepting edge
    task automatic start_conv(input logic [26:0] v);
        start = 1'b1;
        value = v;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done; returns clocks since accept and the busy-high sample count
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (disp !== 48'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got disp=%h busy=%b done=%b ovf=%b, want 0/0/0/0",
                     disp, busy, done, ovf);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero();
        int cyc, bc;
        start_conv(27'd0);
        wait_done(cyc, bc);
        vectors++;
        if (cyc !== 28) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d clocks, want 28", cyc);
        end
        vectors++;
        if (disp !== {42'h0, 6'h20} || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_digits: got %h ovf=%b, want %h ovf=0", disp, ovf, {42'h0, 6'h20});
        end
        vectors++;
        if (disp_dp !== {30'h0, 6'h21, 6'h20, 6'h20}) begin
            miscompares++;
            $display("FAIL zero_dp3_digits: got %h, want %h", disp_dp, {30'h0, 6'h21, 6'h20, 6'h20});
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_one_cycle: got done=%b, want 0", done);
        end
    endtask

    task automatic test_count();
        int cyc, bc;
        start_conv(27'd12_345_678);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b, want 1", busy);
        end
        wait_done(cyc, bc);
        vectors++;
        if (bc !== 28 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_width: got %0d cycles (busy now %b), want 28 (0)", bc, busy);
        end
        vectors++;
        if (disp !== {6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E, 6'h30}) begin
            miscompares++;
            $display("FAIL digits_12345678: got %h, want %h", disp,
                     {6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E, 6'h30});
        end
        vectors++;
        if (disp_dp !== {6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2D, 6'h2E, 6'h30}) begin
            miscompares++;
            $display("FAIL digits_12345678_dp3: got %h, want %h", disp_dp,
                     {6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2D, 6'h2E, 6'h30});
        end
        tick();
    endtask

    task automatic test_dp();
        int cyc, bc;
        start_conv(27'd5);
        wait_done(cyc, bc);
        vectors++;
        if (disp_dp !== {30'h0, 6'h21, 6'h20, 6'h2A}) begin
            miscompares++;
            $display("FAIL dp3_value5: got %h, want %h", disp_dp, {30'h0, 6'h21, 6'h20, 6'h2A});
        end
        vectors++;
        if (disp !== {42'h0, 6'h2A}) begin
            miscompares++;
            $display("FAIL blank_value5: got %h, want %h", disp, {42'h0, 6'h2A});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        start_conv(27'd99_999_999);
        wait_done(cyc, bc);
        vectors++;
        if (disp !== {8{6'h32}} || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL max_value: got %h ovf=%b, want %h ovf=0", disp, ovf, {8{6'h32}});
        end
        // Second start lands in the done cycle and must be taken on the next edge
        start_conv(27'd100_000_000);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy, done);
        end
        wait_done(cyc, bc);
        vectors++;
        if (cyc !== 28) begin
            miscompares++;
            $display("FAIL b2b_latency: got %0d clocks, want 28", cyc);
        end
        vectors++;
        if (disp !== {6'h3C, 42'h0} || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got %h ovf=%b, want %h ovf=1", disp, ovf, {6'h3C, 42'h0});
        end
        vectors++;
        if (disp_dp !== {6'h3C, 42'h0} || ovf_p !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_dp3: got %h ovf=%b, want %h ovf=1", disp_dp, ovf_p, {6'h3C, 42'h0});
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int cyc, bc, dones;
        start_conv(27'd12_345_678);
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (disp !== 48'h0 || disp_dp !== 48'h0 || busy !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: got disp=%h dp=%h busy=%b ovf=%b, want 0/0/0/0",
                     disp, disp_dp, busy, ovf);
        end
        tick();
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 35; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
        end
        start_conv(27'd7);
        wait_done(cyc, bc);
        vectors++;
        if (disp !== {42'h0, 6'h2E} || cyc !== 28) begin
            miscompares++;
            $display("FAIL after_abort: got %h in %0d clocks, want %h in 28", disp, cyc, {42'h0, 6'h2E});
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int first_done, dones;
        start_conv(27'd42);
        first_done = -1;
        dones      = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
            if (i == 4 || i == 19) begin
                start = 1'b1;
                value = 27'd999;
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (dones !== 1 || first_done !== 28) begin
            miscompares++;
            $display("FAIL ignore_start_done: got %0d pulses first at %0d, want 1 at 28", dones, first_done);
        end
        vectors++;
        if (disp !== {36'h0, 6'h28, 6'h24}) begin
            miscompares++;
            $display("FAIL ignore_start_digits: got %h, want %h", disp, {36'h0, 6'h28, 6'h24});
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_count();
        test_dp();
        test_back_to_back();
        test_reset_abort();
        test_ignore_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bin2dspl_formatter.md
Name: bin2dspl_formatter

Overview:
- Sequential producer of the eight 6-bit digit codes consumed by the board's 8-digit multiplexed 7-segment display driver.
- Converts an unsigned 27-bit binary value to 8 BCD digits with a double-dabble engine that processes one bit per clock.
- Applies leading-zero blanking, decimal-point placement and overflow indication.
- Holds the registered digit codes stable between conversions, so the driver never displays a partial result.

Parameters:
- BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all 8 digits.
- DP_POS, 0, 0 = no decimal point; 1..8 = light the decimal point on digit d<DP_POS>. d1 is the rightmost digit.

Ports:
- clock  in  1  system clock (100 MHz on board).
- reset  in  1  asynchronous, active-high.
- start  in  1  request a conversion; sampled only in IDLE.
- value  in  27  unsigned binary value to display; sampled on the accepting edge.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when d1..d8 are updated.
- ovf  out  1  last accepted value was greater than 99_999_999.
- d1..d8  out  6 each  digit code {en, hex[3:0], dp}. en=1 lights the digit. dp=1 lights the point. d1 is the rightmost digit.

Behaviour:
- Reset (asynchronous) state: IDLE, busy=0, done=0, ovf=0, d1..d8=6'h00 (all blank). Internal shift, BCD and count registers are cleared.
- Reset during SHIFT or FORMAT aborts the conversion. No done pulse is generated and outputs are blank.
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE:
  - On start=1 at edge E0: latch value into a 27-bit shift register, clear the 32-bit BCD register, set count=27.
  - Latch ovf_pending = (value > 99_999_999).
  - Set busy=1 and go to SHIFT.
  - With start=0: hold all outputs.
- SHIFT, edges E1..E27, one bit per edge:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, shift} shifts left by 1 and count decrements.
  - The edge on which count==1 moves the FSM to FORMAT.
- FORMAT, edge E28:
  - Register d1..d8 and ovf, pulse done=1, set busy=0, return to IDLE.
  - done is high exactly during the cycle between E28 and E29.
  - Fixed latency: 28 clocks from the accepting edge to the output update, independent of value.
- start while busy=1 is ignored: not queued, and the latched value is unaffected.
- start during the done cycle is accepted, because the FSM is already in IDLE. Back-to-back conversions therefore repeat every 29 clocks.
- Digit encoding: enabled digit n = {1'b1, n[3:0], dp}. Blank = 6'h00, including dp=0.
- Leading-zero blanking when BLANK_LEADING=1:
  - Digit k (k>=2) is blanked when it and all higher digits are 0.
  - d1 is never blanked.
  - Digits at index <= DP_POS are never blanked (e.g. "0.05").
- Decimal point: when DP_POS=k>0, d_k.dp=1. The dp is forced on even if that digit would otherwise be blank, since blanking is suppressed there.
- Overflow (ovf_pending=1):
  - d8=6'h3C ('E' lit), d7..d1=6'h00.
  - DP_POS is ignored; ovf=1.
  - The shift sequence still runs for constant latency.
- Width rule: the BCD register holds 8 nibbles. Any input <= 99_999_999 fits with no carry out of nibble 8.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Default params, value=0, start pulse: done at edge 28 after accept. d1=6'h20, d2..d8=6'h00, ovf=0.
- value=12_345_678: d8..d1 = 22,24,26,28,2A,2C,2E,30 (hex). busy high for exactly 28 cycles.
- value=99_999_999, then value=100_000_000 back-to-back, second start asserted in the done cycle:
  - first result: all digits 6'h32.
  - second result: accepted immediately; d8=6'h3C, others 6'h00, ovf=1.
- DP_POS=3, value=5: d1=6'h2A, d2=6'h20, d3=6'h21, d4..d8=6'h00.
- start re-asserted at cycles 5 and 20 of a conversion of 42: ignored. Exactly one done pulse; d1=6'h24, d2=6'h28.
- Reset asserted at cycle 10 of a conversion: outputs go immediately to 6'h00, busy=0, no done pulse. A fresh start afterwards converts correctly.
